// File: rtl/poly_voice_engine.sv
`default_nettype none
// ============================================================================
// Module   : poly_voice_engine
// Brief    : N-voice oscillator/envelope engine, one shared datapath, saturating mix
// Revision : 1.0
// ============================================================================
module poly_voice_engine #(
  parameter int NVOICES     = 4,
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 6,
  parameter int INCWIDTH    = 21
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_tick,
  input  logic                       cfg_we,
  input  logic [$clog2(NVOICES)-1:0] cfg_voice,
  input  logic [1:0]                 cfg_addr,
  input  logic [INCWIDTH-1:0]        cfg_data,
  output logic [BITDEPTH-1:0]        pcm,
  output logic                       pcm_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int c_VOICE_W = $clog2(NVOICES);
  localparam int c_PHASE_W = BITDEPTH + BITFRACTION;
  localparam int c_ADD_W   = (c_PHASE_W > INCWIDTH) ? c_PHASE_W : INCWIDTH;
  localparam int c_ACC_W   = BITDEPTH + c_VOICE_W;
  localparam int c_PROD_W  = BITDEPTH + 18;
  localparam logic [c_VOICE_W-1:0]      c_LAST_VOICE = c_VOICE_W'(NVOICES - 1);
  localparam logic [15:0]               c_LFSR_MASK  = 16'hB400;
  localparam logic [BITDEPTH-1:0]       c_MID        = {1'b1, {(BITDEPTH-1){1'b0}}};
  localparam logic signed [c_ACC_W-1:0] c_SAT_HI     = c_ACC_W'((2 ** (BITDEPTH-1)) - 1);
  localparam logic signed [c_ACC_W-1:0] c_SAT_LO     = ~c_SAT_HI;
  localparam logic signed [c_ACC_W-1:0] c_OFFSET     = c_ACC_W'(2 ** (BITDEPTH-1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SUM  = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [c_VOICE_W-1:0]       r_vidx;
  logic [INCWIDTH-1:0]        r_inc     [NVOICES];
  logic [1:0]                 r_wave    [NVOICES];
  logic [7:0]                 r_vol     [NVOICES];
  logic                       r_gate    [NVOICES];
  logic [7:0]                 r_attack  [NVOICES];
  logic [7:0]                 r_release [NVOICES];
  logic [c_PHASE_W-1:0]       r_phase   [NVOICES];
  logic [7:0]                 r_env     [NVOICES];
  logic [15:0]                r_lfsr;
  logic signed [c_ACC_W-1:0]  r_acc;

  logic [BITDEPTH-1:0]        w_p, w_p2, w_wave;
  logic signed [BITDEPTH:0]   w_s, w_v;
  logic [15:0]                w_gain;
  logic signed [c_PROD_W-1:0] w_prod;
  logic [c_PHASE_W-1:0]       w_phase_nxt;
  logic [8:0]                 w_env_up;
  logic [7:0]                 w_env_nxt;
  logic [15:0]                w_lfsr_nxt;
  logic signed [c_ACC_W-1:0]  w_sat;
  logic [BITDEPTH-1:0]        w_pcm;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: if (sample_tick) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_vidx == c_LAST_VOICE) w_state_nxt = S_SUM;
      end
      S_SUM: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overrun <= 1'b0;
    else if (sample_tick && r_state != S_IDLE) overrun <= 1'b1;
  end

  // ---------------------------------------------------------- voice config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NVOICES; i++) begin
        r_inc[i]     <= '0;
        r_wave[i]    <= '0;
        r_vol[i]     <= '0;
        r_gate[i]    <= 1'b0;
        r_attack[i]  <= '0;
        r_release[i] <= '0;
      end
    end else if (cfg_we) begin
      case (cfg_addr)
        2'd0: r_inc[cfg_voice]  <= cfg_data;
        2'd1: r_wave[cfg_voice] <= cfg_data[1:0];
        2'd2: r_vol[cfg_voice]  <= cfg_data[7:0];
        default: begin
          r_gate[cfg_voice]    <= cfg_data[16];
          r_attack[cfg_voice]  <= cfg_data[15:8];
          r_release[cfg_voice] <= cfg_data[7:0];
        end
      endcase
    end
  end

  // -------------------------------------------------- shared voice datapath
  assign w_p  = r_phase[r_vidx][c_PHASE_W-1 -: BITDEPTH];
  assign w_p2 = {w_p[BITDEPTH-2:0], 1'b0};

  always_comb begin
    case (r_wave[r_vidx])
      2'd0:    w_wave = w_p;
      2'd1:    w_wave = {BITDEPTH{w_p[BITDEPTH-1]}};
      2'd2:    w_wave = w_p[BITDEPTH-1] ? ~w_p2 : w_p2;
      default: w_wave = r_lfsr[15 -: BITDEPTH];
    endcase
  end

  assign w_s    = $signed({1'b0, w_wave}) - $signed({2'b01, {(BITDEPTH-1){1'b0}}});
  assign w_gain = 16'(r_env[r_vidx]) * 16'(r_vol[r_vidx]);
  assign w_prod = c_PROD_W'(w_s) * c_PROD_W'($signed({1'b0, w_gain}));
  // Arithmetic shift floors toward -inf; the result always fits BITDEPTH+1 bits.
  assign w_v    = (BITDEPTH+1)'(w_prod >>> 16);

  assign w_phase_nxt = c_PHASE_W'(c_ADD_W'(r_phase[r_vidx]) + c_ADD_W'(r_inc[r_vidx]));

  assign w_env_up  = 9'(r_env[r_vidx]) + 9'(r_attack[r_vidx]);
  assign w_env_nxt = r_gate[r_vidx]
                   ? (w_env_up[8] ? 8'hFF : w_env_up[7:0])
                   : ((r_env[r_vidx] >= r_release[r_vidx]) ? r_env[r_vidx] - r_release[r_vidx] : 8'h00);

  assign w_lfsr_nxt = r_lfsr[0] ? ({1'b0, r_lfsr[15:1]} ^ c_LFSR_MASK) : {1'b0, r_lfsr[15:1]};

  always_comb begin
    if (r_acc > c_SAT_HI)      w_sat = c_SAT_HI;
    else if (r_acc < c_SAT_LO) w_sat = c_SAT_LO;
    else                       w_sat = r_acc;
  end
  assign w_pcm = BITDEPTH'(w_sat + c_OFFSET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NVOICES; i++) begin
        r_phase[i] <= '0;
        r_env[i]   <= '0;
      end
      r_vidx    <= '0;
      r_acc     <= '0;
      r_lfsr    <= 16'h0001;
      pcm       <= c_MID;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_vidx <= '0;
          r_acc  <= '0;
        end
        S_RUN: begin
          r_phase[r_vidx] <= w_phase_nxt;
          r_env[r_vidx]   <= w_env_nxt;
          r_acc           <= r_acc + c_ACC_W'(w_v);
          r_vidx          <= r_vidx + 1'b1;
        end
        S_SUM: begin
          pcm       <= w_pcm;
          pcm_valid <= 1'b1;
          r_lfsr    <= w_lfsr_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_voice_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_voice_engine
// Brief    : directed stimulus with a sample-level reference model for poly_voice_engine
// Revision : 1.0
// ============================================================================
module tb_poly_voice_engine;

  localparam int NV = 4;

  logic        clk = 1'b0, rst_n = 1'b0, sample_tick = 1'b0, cfg_we = 1'b0;
  logic [1:0]  cfg_voice = '0, cfg_addr = '0;
  logic [20:0] cfg_data = '0;
  logic [13:0] pcm;
  logic        pcm_valid, busy, overrun;

  int n_checks = 0, n_errors = 0;

  poly_voice_engine #(.NVOICES(4), .BITDEPTH(14), .BITFRACTION(6), .INCWIDTH(21)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .pcm(pcm), .pcm_valid(pcm_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ------------------------------------------------------ reference model
  longint m_inc[NV], m_phase[NV];
  int     m_wave[NV], m_vol[NV], m_gate[NV], m_att[NV], m_rel[NV], m_env[NV];
  longint m_lfsr = 1;
  int     m_pcm = 8192, pending_pcm = 8192;
  bit     m_overrun = 0;
  longint edge_n = 0, busy_from = -10, busy_to = -10, valid_edge = -1;

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_inc[v] = 0; m_phase[v] = 0; m_wave[v] = 0; m_vol[v] = 0;
      m_gate[v] = 0; m_att[v] = 0; m_rel[v] = 0; m_env[v] = 0;
    end
    m_lfsr = 1; m_pcm = 8192; m_overrun = 0;
    busy_from = -10; busy_to = -10; valid_edge = -1;
  endfunction

  // One output sample from the voice state, advancing phases, envelopes and noise.
  function automatic int model_sample();
    longint acc = 0, s, p, w, q;
    for (int v = 0; v < NV; v++) begin
      p = m_phase[v] >> 6;
      case (m_wave[v])
        0: w = p;
        1: w = (p >= 8192) ? 16383 : 0;
        2: begin q = (2 * p) % 16384; w = (p >= 8192) ? 16383 - q : q; end
        default: w = m_lfsr >> 2;
      endcase
      s = w - 8192;
      acc += (s * m_env[v] * m_vol[v]) >>> 16;
      m_phase[v] = (m_phase[v] + m_inc[v]) % (64'd1 << 20);
      if (m_gate[v] != 0) m_env[v] = (m_env[v] + m_att[v] > 255) ? 255 : m_env[v] + m_att[v];
      else                m_env[v] = (m_env[v] < m_rel[v]) ? 0 : m_env[v] - m_rel[v];
    end
    m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 64'hB400) : (m_lfsr >> 1);
    if (acc > 8191)  acc = 8191;
    if (acc < -8192) acc = -8192;
    return int'(acc + 8192);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      edge_n++;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: m_inc[cfg_voice]  = cfg_data;
          2'd1: m_wave[cfg_voice] = cfg_data[1:0];
          2'd2: m_vol[cfg_voice]  = cfg_data[7:0];
          default: begin
            m_gate[cfg_voice] = cfg_data[16];
            m_att[cfg_voice]  = cfg_data[15:8];
            m_rel[cfg_voice]  = cfg_data[7:0];
          end
        endcase
      end
      if (sample_tick) begin
        if (edge_n - 1 >= busy_from && edge_n - 1 <= busy_to) m_overrun = 1;
        else begin
          pending_pcm = model_sample();
          busy_from   = edge_n;
          busy_to     = edge_n + NV;
          valid_edge  = edge_n + NV + 1;
        end
      end
      if (edge_n == valid_edge) m_pcm = pending_pcm;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("pcm_valid", pcm_valid, (edge_n == valid_edge) ? 1 : 0);
      check("pcm", pcm, m_pcm);
      check("busy", busy, (edge_n >= busy_from && edge_n <= busy_to) ? 1 : 0);
      check("overrun", overrun, m_overrun);
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic cfg(input int v, input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = v[1:0]; cfg_addr = a[1:0]; cfg_data = d[20:0];
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  function automatic int env_word(input int gate, input int att, input int rel);
    return (gate << 16) | (att << 8) | rel;
  endfunction

  task automatic run_tick(output int got, output int lat);
    got = -1; lat = -1;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (pcm_valid === 1'b1) begin got = pcm; lat = k; break; end
    end
    if (lat < 0) begin
      n_checks++; n_errors++;
      $display("FAIL tick_timeout: got no pcm_valid, required one within 20 cycles");
    end
  endtask

  task automatic tick_expect(input string name, input int exp);
    int g, l;
    run_tick(g, l);
    check(name, g, exp);
  endtask

  task automatic ticks(input int n);
    int g, l;
    for (int i = 0; i < n; i++) run_tick(g, l);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; #1;
    check("rst_pcm", pcm, 8192);
    check("rst_busy", busy, 0);
    check("rst_valid", pcm_valid, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, l, prev, cnt;
    repeat (2) @(negedge clk);
    do_reset();

    // 1: saw voice, env preloaded with increment 0, then walk phase
    cfg(0, 1, 0); cfg(0, 2, 255); cfg(0, 3, env_word(1, 255, 0)); cfg(0, 0, 0);
    tick_expect("t1_preload", 8192);
    cfg(0, 0, 64);
    run_tick(g, l);
    check("t1_p0", g, 63);
    check("t1_latency", l, NV + 1);
    tick_expect("t1_p1", 64);

    // 2: four square voices saturate both ways
    do_reset();
    for (int v = 0; v < NV; v++) begin
      cfg(v, 1, 1); cfg(v, 2, 255); cfg(v, 3, env_word(1, 255, 0));
    end
    tick_expect("t2_preload", 8192);
    for (int v = 0; v < NV; v++) cfg(v, 0, 1 << 19);
    tick_expect("t2_neg_sat", 0);
    tick_expect("t2_pos_sat", 16383);

    // 3: attack ramp and fast release
    do_reset();
    cfg(0, 2, 255); cfg(0, 3, env_word(1, 16, 0));
    tick_expect("t3_env0", 8192);
    tick_expect("t3_env16", 7682);
    ticks(14);
    tick_expect("t3_env255", 63);
    tick_expect("t3_env_held", 63);
    cfg(0, 3, env_word(0, 0, 255));
    tick_expect("t3_rel_last", 63);
    tick_expect("t3_released", 8192);

    // 4: tick while busy
    do_reset();
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (pcm_valid === 1'b1) cnt++;
    end
    check("t4_valid_count", cnt, 1);
    check("t4_overrun", overrun, 1);
    ticks(2);
    check("t4_overrun_sticky", overrun, 1);

    // 5: reset in the middle of a run
    do_reset();
    cfg(0, 2, 255); cfg(0, 3, env_word(1, 255, 0));
    ticks(1);
    tick_expect("t5_before", 63);
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk);
    check("t5_busy_before", busy, 1);
    rst_n = 1'b0; #1;
    check("t5_rst_pcm", pcm, 8192);
    check("t5_rst_busy", busy, 0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pcm_valid === 1'b1) cnt++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (pcm_valid === 1'b1) cnt++;
    end
    check("t5_no_valid", cnt, 0);
    tick_expect("t5_after", 8192);

    // 6: noise voice follows the LFSR
    do_reset();
    cfg(1, 1, 3); cfg(1, 2, 255); cfg(1, 3, env_word(1, 255, 0));
    tick_expect("t6_preload", 8192);
    tick_expect("t6_first_noise", 11494);
    prev = 11494;
    for (int i = 0; i < 6; i++) begin
      run_tick(g, l);
      check("t6_changes", (g != prev) ? 1 : 0, 1);
      prev = g;
    end

    // 7: mixed triangle/saw/square voices at partial levels
    do_reset();
    cfg(0, 1, 2); cfg(0, 2, 128); cfg(0, 3, env_word(1, 255, 0)); cfg(0, 0, 32'h2F3A1);
    cfg(1, 1, 0); cfg(1, 2, 200); cfg(1, 3, env_word(1, 100, 0)); cfg(1, 0, 32'h51234);
    cfg(2, 1, 1); cfg(2, 2, 60);  cfg(2, 3, env_word(1, 40, 0));  cfg(2, 0, 32'h0C000);
    ticks(10);
    cfg(1, 3, env_word(0, 0, 30));
    ticks(6);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
